// File: rtl/sprite_scheduler_if.sv
// Frame/line timing, shadow-table write port and renderer handshake for sprite_scheduler.
// Defining SPRITE_COLLISION_EN adds the collision and collision_mask signals.
interface sprite_scheduler_if #(
    parameter int NUM_SLOTS = 8
);
    localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    logic                 frame_start;
    logic                 line_start;
    logic [9:0]           pixel_y;
    logic                 wr_en;
    logic [IDX_W-1:0]     wr_slot;
    logic [9:0]           wr_y;
    logic                 wr_valid;
    logic [NUM_SLOTS-1:0] spr_draw_vec;
    logic [NUM_SLOTS-1:0] start_vec;
    logic [NUM_SLOTS-1:0] busy_vec;
    logic                 pix_valid;
    logic [IDX_W-1:0]     pix_slot;
`ifdef SPRITE_COLLISION_EN
    logic                 collision;
    logic [NUM_SLOTS-1:0] collision_mask;
`endif

    // Host / video-timing side
    modport master (
`ifdef SPRITE_COLLISION_EN
        input  collision, collision_mask,
`endif
        output frame_start, line_start, pixel_y,
        output wr_en, wr_slot, wr_y, wr_valid, spr_draw_vec,
        input  start_vec, busy_vec, pix_valid, pix_slot
    );

    // Scheduler side
    modport slave (
`ifdef SPRITE_COLLISION_EN
        output collision, collision_mask,
`endif
        input  frame_start, line_start, pixel_y,
        input  wr_en, wr_slot, wr_y, wr_valid, spr_draw_vec,
        output start_vec, busy_vec, pix_valid, pix_slot
    );
endinterface

// File: rtl/sprite_scheduler.sv
// Per-line sprite slot scheduler: double-buffered y table, one-slot-per-cycle scan, pixel merge.
// Optional collision tracking is enabled with SPRITE_COLLISION_EN.
module sprite_slot #(
    parameter int LINES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic load,
    input  logic dec,
    output logic busy
);
    localparam int CNT_W = $clog2(LINES + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  cnt <= '0;
        else if (clr)                cnt <= '0;
        else if (load)               cnt <= CNT_W'(LINES);
        else if (dec && cnt != '0)   cnt <= cnt - 1'b1;
    end

    assign busy = (cnt != '0);
endmodule

module sprite_scheduler #(
    parameter int NUM_SLOTS     = 8,
    parameter int SPRITE_HEIGHT = 8,
    parameter int SPRITE_SCALE  = 2
) (
    input logic               clk,
    input logic               rst_n,
    sprite_scheduler_if.slave bus
);
    localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int LINES = SPRITE_HEIGHT * SPRITE_SCALE;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                    state, state_nxt;
    logic [IDX_W-1:0]          idx, idx_nxt;
    logic [NUM_SLOTS-1:0]      shd_valid, act_valid;
    logic [NUM_SLOTS-1:0][9:0] shd_y, act_y;
    logic [NUM_SLOTS-1:0]      start, busy;
    logic                      dec;
    logic                      pix_valid_nxt;
    logic [IDX_W-1:0]          pix_slot_nxt;

    // Active table only changes at frame boundaries so a frame renders from one consistent snapshot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shd_valid <= '0;
            shd_y     <= '0;
            act_valid <= '0;
            act_y     <= '0;
        end else begin
            if (bus.frame_start) begin
                act_valid <= shd_valid;
                act_y     <= shd_y;
            end
            if (bus.wr_en) begin
                shd_valid[bus.wr_slot] <= bus.wr_valid;
                shd_y[bus.wr_slot]     <= bus.wr_y;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        start     = '0;
        if (bus.frame_start) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
        end else begin
            case (state)
                IDLE: if (bus.line_start) begin
                    state_nxt = SCAN;
                    idx_nxt   = '0;
                end
                SCAN: begin
                    if (act_valid[idx] && act_y[idx] == bus.pixel_y && !busy[idx])
                        start[idx] = 1'b1;
                    if (idx == IDX_W'(NUM_SLOTS - 1)) begin
                        state_nxt = IDLE;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Counters age only on line_starts the FSM accepts; the starting line itself never counts
    assign dec = bus.line_start && (state == IDLE) && !bus.frame_start;

    sprite_slot #(.LINES(LINES)) u_slot [NUM_SLOTS-1:0] (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (bus.frame_start),
        .load (start),
        .dec  (dec),
        .busy (busy)
    );

    assign bus.start_vec = start;
    assign bus.busy_vec  = busy;

    always_comb begin
        pix_valid_nxt = |bus.spr_draw_vec;
        pix_slot_nxt  = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--)
            if (bus.spr_draw_vec[i]) pix_slot_nxt = IDX_W'(i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.pix_valid <= 1'b0;
            bus.pix_slot  <= '0;
        end else begin
            bus.pix_valid <= pix_valid_nxt;
            bus.pix_slot  <= pix_slot_nxt;
        end
    end

`ifdef SPRITE_COLLISION_EN
    logic [NUM_SLOTS-1:0] mask;

    // x & (x-1) is nonzero exactly when two or more bits are set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mask <= '0;
        else if (bus.frame_start)
            mask <= '0;
        else if ((bus.spr_draw_vec & (bus.spr_draw_vec - 1'b1)) != '0)
            mask <= mask | bus.spr_draw_vec;
    end

    assign bus.collision_mask = mask;
    assign bus.collision      = (mask != '0);
`endif
endmodule

// File: tb/tb_sprite_scheduler.sv
// Bench for sprite_scheduler: directed vector table, hand sequences for frame/reset corners,
// and randomized traffic checked cycle by cycle against a line/slot-level reference model.
module tb_sprite_scheduler;
    localparam int N     = 8;
    localparam int H     = 8;
    localparam int S     = 2;
    localparam int LINES = H * S;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sprite_scheduler_if #(.NUM_SLOTS(N)) bus();

    sprite_scheduler #(.NUM_SLOTS(N), .SPRITE_HEIGHT(H), .SPRITE_SCALE(S)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic       fs, ls, we;
        logic [2:0] ws;
        logic [9:0] wy;
        logic       wv;
        logic [9:0] py;
        logic [7:0] draw;
        logic [7:0] e_start, e_busy;
        logic       e_pv;
        logic [2:0] e_ps;
        logic [7:0] e_mask;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // reference model: tables, remaining lines per slot, cycles since accepted line_start
    bit         m_shv[N];
    int         m_shy[N];
    bit         m_acv[N];
    int         m_acy[N];
    int         m_rem[N];
    int         m_since;
    logic [7:0] m_prev_draw, m_mask;

    logic [7:0] smp_start, smp_busy, smp_mask, start_or;
    logic       smp_pv;
    logic [2:0] smp_ps;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int k = 0; k < N; k++) begin
            m_shv[k] = 0; m_shy[k] = 0; m_acv[k] = 0; m_acy[k] = 0; m_rem[k] = 0;
        end
        m_since     = 0;
        m_prev_draw = '0;
        m_mask      = '0;
    endtask

    function automatic logic [7:0] m_start();
        logic [7:0] r;
        int k;
        r = '0;
        if (m_since > 0 && !bus.frame_start) begin
            k = m_since - 1;
            if (m_acv[k] && m_acy[k] == int'(bus.pixel_y) && m_rem[k] == 0) r[k] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [7:0] m_busy();
        logic [7:0] r;
        for (int k = 0; k < N; k++) r[k] = (m_rem[k] != 0);
        return r;
    endfunction

    function automatic logic [2:0] m_lowest(input logic [7:0] d);
        int k;
        k = 0;
        while (k < N && !d[k]) k++;
        return (k == N) ? 3'd0 : 3'(k);
    endfunction

    task automatic m_step();
        logic [7:0] st;
        st = m_start();
        if (bus.frame_start) begin
            for (int k = 0; k < N; k++) begin
                m_acv[k] = m_shv[k]; m_acy[k] = m_shy[k]; m_rem[k] = 0;
            end
            m_since = 0;
        end else begin
            for (int k = 0; k < N; k++) if (st[k]) m_rem[k] = LINES;
            if (m_since == 0) begin
                if (bus.line_start) begin
                    m_since = 1;
                    for (int k = 0; k < N; k++) if (m_rem[k] > 0) m_rem[k]--;
                end
            end else begin
                m_since = (m_since == N) ? 0 : m_since + 1;
            end
        end
        if (bus.wr_en) begin
            m_shv[bus.wr_slot] = bus.wr_valid;
            m_shy[bus.wr_slot] = int'(bus.wr_y);
        end
        if (bus.frame_start) m_mask = '0;
        else if ($countones(bus.spr_draw_vec) >= 2) m_mask = m_mask | bus.spr_draw_vec;
        m_prev_draw = bus.spr_draw_vec;
    endtask

    function automatic vec_t mk(input logic fs, input logic ls, input logic [9:0] py,
                                input logic [7:0] draw);
        vec_t v;
        v = '{fs: fs, ls: ls, we: 1'b0, ws: 3'd0, wy: 10'd0, wv: 1'b0, py: py, draw: draw,
              e_start: 8'h0, e_busy: 8'h0, e_pv: 1'b0, e_ps: 3'd0, e_mask: 8'h0};
        return v;
    endfunction

    function automatic vec_t mkw(input logic [2:0] ws, input logic [9:0] wy, input logic fs);
        vec_t v;
        v = mk(fs, 1'b0, 10'd0, 8'h0);
        v.we = 1'b1; v.ws = ws; v.wy = wy; v.wv = 1'b1;
        return v;
    endfunction

    // Drive one cycle (entered just after a rising edge), compare on the falling edge
    task automatic cyc(input vec_t v);
        bus.frame_start  = v.fs;
        bus.line_start   = v.ls;
        bus.wr_en        = v.we;
        bus.wr_slot      = v.ws;
        bus.wr_y         = v.wy;
        bus.wr_valid     = v.wv;
        bus.pixel_y      = v.py;
        bus.spr_draw_vec = v.draw;
        @(negedge clk);
        smp_start = bus.start_vec;
        smp_busy  = bus.busy_vec;
        smp_pv    = bus.pix_valid;
        smp_ps    = bus.pix_slot;
        start_or  = start_or | smp_start;
        check("start_vec", smp_start, m_start());
        check("busy_vec", smp_busy, m_busy());
        check("pix_valid", smp_pv, |m_prev_draw);
        check("pix_slot", smp_ps, m_lowest(m_prev_draw));
`ifdef SPRITE_COLLISION_EN
        smp_mask = bus.collision_mask;
        check("collision_mask", smp_mask, m_mask);
        check("collision", bus.collision, m_mask != 8'h0);
`else
        smp_mask = m_mask;
`endif
        m_step();
        @(posedge clk);
        #1;
    endtask

    task automatic line(input logic [9:0] py);
        cyc(mk(1'b0, 1'b1, py, 8'h0));
        repeat (N + 1) cyc(mk(1'b0, 1'b0, py, 8'h0));
    endtask

    vec_t tbl[12];

    initial begin
        // slot 2 at y=100 through one full line, with a two-sprite overlap on the draw bus
        tbl[0]  = mkw(3'd2, 10'd100, 1'b0);
        tbl[1]  = mk(1'b1, 1'b0, 10'd0, 8'h0);
        tbl[2]  = mk(1'b0, 1'b1, 10'd100, 8'h0);
        for (int i = 3; i < 12; i++) tbl[i] = mk(1'b0, 1'b0, 10'd100, 8'h0);
        tbl[5].e_start = 8'h04;
        tbl[6].draw    = 8'b0010_1000;
        for (int i = 6; i < 12; i++) tbl[i].e_busy = 8'h04;
        tbl[7].e_pv = 1'b1;
        tbl[7].e_ps = 3'd3;
        for (int i = 7; i < 12; i++) tbl[i].e_mask = 8'b0010_1000;

        bus.frame_start = 0; bus.line_start = 0; bus.pixel_y = '0;
        bus.wr_en = 0; bus.wr_slot = '0; bus.wr_y = '0; bus.wr_valid = 0;
        bus.spr_draw_vec = '0;
        start_or = '0;
        m_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_start", bus.start_vec, 8'h0);
        check("rst_busy", bus.busy_vec, 8'h0);
        check("rst_pix_valid", bus.pix_valid, 1'b0);
        check("rst_pix_slot", bus.pix_slot, 3'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i]);
            check($sformatf("tbl%0d_start", i), smp_start, tbl[i].e_start);
            check($sformatf("tbl%0d_busy", i), smp_busy, tbl[i].e_busy);
            check($sformatf("tbl%0d_pv", i), smp_pv, tbl[i].e_pv);
            check($sformatf("tbl%0d_ps", i), smp_ps, tbl[i].e_ps);
`ifdef SPRITE_COLLISION_EN
            check($sformatf("tbl%0d_mask", i), smp_mask, tbl[i].e_mask);
`endif
        end

        // busy spans exactly 16 further line_starts, no restart on y=101..116
        start_or = '0;
        for (int y = 101; y <= 116; y++) begin
            line(10'(y));
            check($sformatf("busy2_after_y%0d", y), smp_busy[2], (y < 116));
        end
        check("no_restart_slot2", start_or, 8'h0);

        // shadow write is invisible until the next frame_start
        cyc(mkw(3'd0, 10'd50, 1'b0));
        start_or = '0;
        line(10'd50);
        check("shadow_only_no_start", start_or, 8'h0);
        cyc(mk(1'b1, 1'b0, 10'd0, 8'h0));
        start_or = '0;
        line(10'd50);
        check("after_frame_start0", start_or, 8'h01);

        // frame_start + line_start mid-scan with slot 5 matching
        cyc(mkw(3'd5, 10'd200, 1'b1));
        cyc(mk(1'b1, 1'b0, 10'd0, 8'h0));
        cyc(mk(1'b0, 1'b1, 10'd200, 8'h0));
        cyc(mk(1'b0, 1'b0, 10'd200, 8'h0));
        cyc(mk(1'b0, 1'b0, 10'd200, 8'h0));
        start_or = '0;
        cyc(mk(1'b1, 1'b1, 10'd200, 8'h0));
        repeat (10) cyc(mk(1'b0, 1'b0, 10'd200, 8'h0));
        check("abort_no_start", start_or, 8'h0);
        check("abort_busy", smp_busy, 8'h0);

        // reset dropped mid-scan while slot 5 is busy
        start_or = '0;
        line(10'd200);
        check("slot5_started", start_or, 8'h20);
        cyc(mk(1'b0, 1'b1, 10'd200, 8'h3));
        cyc(mk(1'b0, 1'b0, 10'd200, 8'h0));
        check("slot5_busy_pre_rst", smp_busy[5], 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_rst_start", bus.start_vec, 8'h0);
        check("async_rst_busy", bus.busy_vec, 8'h0);
        check("async_rst_pv", bus.pix_valid, 1'b0);
        check("async_rst_ps", bus.pix_slot, 3'd0);
        m_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        start_or = '0;
        repeat (12) cyc(mk(1'b0, 1'b0, 10'd200, 8'h0));
        check("post_rst_no_start", start_or, 8'h0);

        // randomized traffic on a small y range so matches are frequent
        begin
            vec_t v;
            logic [9:0] py;
            py = '0;
            for (int i = 0; i < 4000; i++) begin
                v = mk(($urandom % 150) == 0, ($urandom % 5) == 0, py, 8'($urandom));
                if (v.ls) py = 10'($urandom_range(0, 3));
                v.py = py;
                if (($urandom % 4) == 0) begin
                    v.we = 1'b1;
                    v.ws = 3'($urandom);
                    v.wy = 10'($urandom_range(0, 3));
                    v.wv = ($urandom % 4) != 0;
                end
                if (($urandom % 8) != 0) v.draw = v.draw & 8'($urandom) & 8'($urandom);
                cyc(v);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sprite_scheduler.md
SPRITE_SCHEDULER -- requirements
Module: sprite_scheduler

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 8: number of sprite slots, one per downstream sprite renderer.
REQ-002 SHALL have parameter SPRITE_HEIGHT, default 8: sprite height in bitmap rows.
REQ-003 SHALL have parameter SPRITE_SCALE, default 2: screen lines per bitmap row.
REQ-004 SHALL have port clk  input  1: sole clock, all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-006 SHALL have port frame_start  input  1: one-cycle pulse at the start of each frame.
REQ-007 SHALL have port line_start  input  1: one-cycle pulse at the start of each visible line.
REQ-008 SHALL have port pixel_y  input  10: current line number, stable from line_start through the end of the scan.
REQ-009 SHALL have port wr_en  input  1: shadow-table write strobe.
REQ-010 SHALL have port wr_slot  input  clog2(NUM_SLOTS): slot to write.
REQ-011 SHALL have port wr_y  input  10: top line of the sprite.
REQ-012 SHALL have port wr_valid  input  1: slot enable.
REQ-013 SHALL have port spr_draw_vec  input  NUM_SLOTS: per-slot draw bits from the renderers.
REQ-014 SHALL have port start_vec  output  NUM_SLOTS: per-slot one-cycle start pulses.
REQ-015 SHALL have port busy_vec  output  NUM_SLOTS: slot currently rendering.
REQ-016 SHALL have port pix_valid  output  1: a sprite pixel is drawn this cycle.
REQ-017 SHALL have port pix_slot  output  clog2(NUM_SLOTS): winning slot index.

Function
REQ-018 SHALL hold a shadow table and an active table, each with valid and y per slot; wr_en writes only the shadow table.
REQ-019 SHALL copy shadow to active on frame_start; a write in the same cycle lands in shadow after the copy and becomes active only at the next frame_start.
REQ-020 SHALL have FSM states IDLE and SCAN, with a scan index idx.
REQ-021 SHALL transition IDLE->SCAN on line_start with idx=0; SCAN examines one slot per cycle, then idx increments; after idx==NUM_SLOTS-1 the FSM returns to IDLE.
REQ-022 SHALL, in SCAN, pulse start_vec[idx] for exactly one cycle if active valid[idx], active y[idx]==pixel_y and busy_vec[idx]==0; slot k pulses in cycle k+1 after the line_start cycle.
REQ-023 SHALL, on a start pulse, load slot line counter with SPRITE_HEIGHT*SPRITE_SCALE; busy_vec[k] = (counter != 0).
REQ-024 SHALL decrement every nonzero line counter on each subsequent line_start (not on the starting line), so busy lasts exactly SPRITE_HEIGHT*SPRITE_SCALE line_starts.
REQ-025 SHALL ignore line_start while in SCAN: no restart and no counter decrement.
REQ-026 SHALL, on frame_start, clear all line counters, abort any scan to IDLE, and suppress start pulses that cycle; frame_start wins over a simultaneous line_start.
REQ-027 SHALL register the pixel merge with 1-cycle latency: pix_valid = OR(spr_draw_vec); pix_slot = lowest set index, or 0 when none.
REQ-028 SHALL compare y at full 10-bit width; a y value never reached gives no start and no wrap.

Reset
REQ-029 SHALL, while rst_n is low, force: FSM to IDLE, idx 0, both tables invalid with y 0, counters 0, start_vec 0, busy_vec 0, pix_valid 0, pix_slot 0.
REQ-030 SHALL, on reset release mid-scan, produce no residual start pulse; the first activity follows the next line_start.

Configuration
REQ-031 SHALL, when macro SPRITE_COLLISION_EN is defined, add output collision (1) and collision_mask (NUM_SLOTS).
REQ-032 With SPRITE_COLLISION_EN, collision_mask SHALL OR-accumulate spr_draw_vec in every cycle where two or more of its bits are set, and collision SHALL equal (mask != 0).
REQ-033 With SPRITE_COLLISION_EN, both outputs SHALL be cleared on frame_start and on reset; without the macro the ports and logic SHALL be absent.

Verification
REQ-034 Slot 2 written y=100 valid, then frame_start, then line_start with pixel_y=100 -> start_vec=8'b0000_0100 exactly 3 cycles after line_start, and busy_vec[2]=1.
REQ-035 Continue with line_starts at y=101..116 -> no further start; busy_vec[2] falls on the 16th line_start (8x2).
REQ-036 Write slot 0 y=50 without a frame_start, then line at y=50 -> no start; after frame_start, the next y=50 line -> start_vec[0] pulses.
REQ-037 spr_draw_vec=8'b0010_1000 -> next cycle pix_valid=1, pix_slot=3; with SPRITE_COLLISION_EN, collision=1 and collision_mask=8'b0010_1000.
REQ-038 frame_start and line_start in the same cycle during SCAN with slot 5 matching -> scan aborted, no start pulse, all busy_vec bits 0.
REQ-039 Drop rst_n during SCAN -> all outputs 0 immediately; after release, no start pulse until a new line_start.
